fifo_burst_reader: RTL



---
 rtl/fifo_burst_reader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fifo_burst_reader.sv
// Burst read controller: pops burst_len FIFO words into a 2-deep skid stream.
// Optional m_last output when BURST_LAST_EN is defined.
module fifo_burst_reader #(
   parameter int DATA_SIZE = 8,
   parameter int LEN_BITS  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [LEN_BITS-1:0]  burst_len,
   input  logic                 fifo_empty,
   input  logic [DATA_SIZE-1:0] fifo_rdata,
   output logic                 fifo_ren,
   output logic                 m_valid,
   output logic [DATA_SIZE-1:0] m_data,
   input  logic                 m_ready,
   output logic                 busy,
`ifdef BURST_LAST_EN
   output logic                 m_last,
`endif
   output logic                 done
);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } state_t;

   state_t               r_state;
   logic [LEN_BITS-1:0]  r_len;
   logic [LEN_BITS-1:0]  r_issued;
   logic [LEN_BITS-1:0]  r_deliv;
   logic                 r_inflight;
   logic [1:0]           r_occ;
   logic [DATA_SIZE-1:0] r_buf0;
   logic [DATA_SIZE-1:0] r_buf1;

   logic                 w_valid;
   logic                 w_pop;
   logic [2:0]           w_level;
   logic                 w_ren;

   assign w_valid = (r_occ != 2'd0);
   assign w_pop   = w_valid && m_ready;

   // Occupancy after this edge, counting the word still in flight.
   assign w_level = {1'b0, r_occ}
                  + {2'b00, r_inflight}
                  - {2'b00, w_pop};

   assign w_ren = (r_state == READ)
               && !fifo_empty
               && (r_issued < r_len)
               && (w_level < 3'd2);

   assign fifo_ren = w_ren;
   assign m_valid  = w_valid;
   assign m_data   = r_buf0;
   assign busy     = (r_state != IDLE);
   assign done     = (r_state == DONE);

`ifdef BURST_LAST_EN
   assign m_last = w_valid
                && (r_deliv == LEN_BITS'(r_len - 1'b1));
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_len    <= '0;
         r_issued <= '0;
         r_deliv  <= '0;
      end else begin
         if (w_pop)
            r_deliv <= r_deliv + 1'b1;
         unique case (r_state)
            IDLE: begin
               if (start && (burst_len != '0)) begin
                  r_len    <= burst_len;
                  r_issued <= '0;
                  r_deliv  <= '0;
                  r_state  <= READ;
               end
            end
            READ: begin
               if (w_ren) begin
                  r_issued <= r_issued + 1'b1;
                  if (LEN_BITS'(r_issued + 1'b1) == r_len)
                     r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (r_deliv == r_len)
                  r_state <= DONE;
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_inflight <= 1'b0;
         r_occ      <= 2'd0;
         r_buf0     <= '0;
         r_buf1     <= '0;
      end else begin
         r_inflight <= w_ren;
         case ({r_inflight, w_pop})
            2'b10: begin
               if (r_occ == 2'd0)
                  r_buf0 <= fifo_rdata;
               else
                  r_buf1 <= fifo_rdata;
               r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
               r_buf0 <= r_buf1;
               r_occ  <= r_occ - 2'd1;
            end
            2'b11: begin
               // Shift and refill together so FIFO order survives.
               if (r_occ == 2'd1) begin
                  r_buf0 <= fifo_rdata;
               end else begin
                  r_buf0 <= r_buf1;
                  r_buf1 <= fifo_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
